// File: rtl/ps2_pkg.sv
// Shared constants, decoder state encoding and frame helpers for the PS/2 keyboard receiver.
package ps2_pkg;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } dec_state_t;

    // Frame is stored LSB = first bit received (start bit).
    // Valid when start=0, stop=1 and data+parity hold an odd number of ones.
    function automatic logic frame_ok(logic [FRAME_BITS-1:0] f);
        return (f[0] == 1'b0) && f[FRAME_BITS-1] && (^f[FRAME_BITS-2:1]);
    endfunction

endpackage

// File: rtl/ps2_key_if.sv
// PS/2 line pair plus decoded ASCII output and decoder state for observation.
// The device side (master) drives the PS/2 lines; ps2_key (slave) drives ps2_ascii
// and exposes its decoder state on state_dbg.
interface ps2_key_if;

    logic                ps2_clk;
    logic                ps2_data;
    logic [31:0]         ps2_ascii;
    ps2_pkg::dec_state_t state_dbg;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  ps2_ascii,
        input  state_dbg
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ps2_ascii,
        output state_dbg
    );

endinterface

// File: rtl/ps2_scan2ascii.sv
// Combinational scan code set 2 to ASCII lookup; valid flags a mapped code.
module ps2_scan2ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii,
    output logic       valid
);

    logic [7:0] base;
    logic       is_letter;

    // Table lookup; letters are stored lowercase and folded to uppercase under shift.
    always_comb begin
        base      = 8'h00;
        is_letter = 1'b1;
        valid     = 1'b1;
        case (code)
            8'h1C: base = 8'h61; 8'h32: base = 8'h62; 8'h21: base = 8'h63;
            8'h23: base = 8'h64; 8'h24: base = 8'h65; 8'h2B: base = 8'h66;
            8'h34: base = 8'h67; 8'h33: base = 8'h68; 8'h43: base = 8'h69;
            8'h3B: base = 8'h6A; 8'h42: base = 8'h6B; 8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D; 8'h31: base = 8'h6E; 8'h44: base = 8'h6F;
            8'h4D: base = 8'h70; 8'h15: base = 8'h71; 8'h2D: base = 8'h72;
            8'h1B: base = 8'h73; 8'h2C: base = 8'h74; 8'h3C: base = 8'h75;
            8'h2A: base = 8'h76; 8'h1D: base = 8'h77; 8'h22: base = 8'h78;
            8'h35: base = 8'h79; 8'h1A: base = 8'h7A;
            default: begin
                is_letter = 1'b0;
                case (code)
                    8'h45: base = 8'h30; 8'h16: base = 8'h31; 8'h1E: base = 8'h32;
                    8'h26: base = 8'h33; 8'h25: base = 8'h34; 8'h2E: base = 8'h35;
                    8'h36: base = 8'h36; 8'h3D: base = 8'h37; 8'h3E: base = 8'h38;
                    8'h46: base = 8'h39;
                    8'h29: base = 8'h20; 8'h5A: base = 8'h0D; 8'h66: base = 8'h08;
                    8'h0D: base = 8'h09; 8'h76: base = 8'h1B;
                    default: valid = 1'b0;
                endcase
            end
        endcase
        ascii = (is_letter && shift) ? (base - 8'h20) : base;
    end

endmodule

// File: rtl/ps2_key.sv
// PS/2 keyboard receiver: synchronizes the PS/2 lines, assembles 11-bit frames,
// tracks make/break/extended prefixes and shift keys, and presents the ASCII
// code of the currently held key.
module ps2_key #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic      sys_clk,
    input  logic      rst,
    ps2_key_if.slave  bus
);
    import ps2_pkg::*;

    localparam int          TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  BIT_LAST = 4'(FRAME_BITS - 1);

    // Receiver state
    logic                  clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
    logic                  dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  fall;
    // byte_stb: single-cycle strobe, no back-pressure; rx_byte is valid only while it is high.
    logic                  byte_stb;
    logic [7:0]            rx_byte;

    // Decoder state
    dec_state_t            state_q, state_d;
    logic                  shl_q, shl_d, shr_q, shr_d;
    logic [7:0]            held_q, held_d;
    logic [7:0]            ascii_q, ascii_d;
    logic [7:0]            map_ascii;
    logic                  map_valid;

    ps2_scan2ascii u_map (
        .code  (rx_byte),
        .shift (shl_q | shr_q),
        .ascii (map_ascii),
        .valid (map_valid)
    );

    // Synchronizers, falling-edge detect, frame shift register, bit and idle counters.
    always_comb begin
        clk_s1_d   = bus.ps2_clk;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        dat_s1_d   = bus.ps2_data;
        dat_s2_d   = dat_s1_q;
        fall       = clk_prev_q & ~clk_s2_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        to_cnt_d   = to_cnt_q;
        byte_stb   = 1'b0;
        if (fall) begin
            shift_d  = {dat_s2_q, shift_q[FRAME_BITS-1:1]};
            to_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d = 4'd0;
                byte_stb  = frame_ok(shift_d);
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            // Device went quiet mid-frame: drop the partial frame.
            if (to_cnt_q == TO_LAST) begin
                bit_cnt_d = 4'd0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
        rx_byte = shift_d[8:1];
    end

    // Decoder: prefix tracking, shift flags, held key and output latch.
    always_comb begin
        state_d = state_q;
        shl_d   = shl_q;
        shr_d   = shr_q;
        held_d  = held_q;
        ascii_d = ascii_q;
        if (byte_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == CODE_BREAK)       state_d = ST_BREAK;
                    else if (rx_byte == CODE_EXT)    state_d = ST_EXT;
                    else if (rx_byte == CODE_LSHIFT) shl_d = 1'b1;
                    else if (rx_byte == CODE_RSHIFT) shr_d = 1'b1;
                    else if (map_valid && rx_byte != held_q) begin
                        // Typematic repeats of the held key fall through unchanged.
                        held_d  = rx_byte;
                        ascii_d = map_ascii;
                    end
                end
                ST_BREAK: begin
                    state_d = ST_IDLE;
                    if (rx_byte == CODE_LSHIFT)      shl_d = 1'b0;
                    else if (rx_byte == CODE_RSHIFT) shr_d = 1'b0;
                    else if (held_q != 8'h00 && rx_byte == held_q) begin
                        held_d  = 8'h00;
                        ascii_d = 8'h00;
                    end
                end
                ST_EXT: begin
                    state_d = (rx_byte == CODE_BREAK) ? ST_EXT_BREAK : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; synchronizers reset to the idle-high bus level.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= 4'd0;
            to_cnt_q   <= '0;
            state_q    <= ST_IDLE;
            shl_q      <= 1'b0;
            shr_q      <= 1'b0;
            held_q     <= 8'h00;
            ascii_q    <= 8'h00;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_prev_q <= clk_prev_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            to_cnt_q   <= to_cnt_d;
            state_q    <= state_d;
            shl_q      <= shl_d;
            shr_q      <= shr_d;
            held_q     <= held_d;
            ascii_q    <= ascii_d;
        end
    end

    assign bus.ps2_ascii = {24'h000000, ascii_q};
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ps2_key.sv
// Bench for ps2_key: bit-banged PS/2 frames, table of scan codes with expected
// ASCII after each frame, plus timeout and mid-frame reset sequences.
module tb_ps2_key;
  import ps2_pkg::*;

  localparam int TO   = 200;
  localparam int HALF = 20;
  localparam int GAP  = 60;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_key_if bus();

  ps2_key #(.TIMEOUT_CYCLES(TO)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0]  code;
    logic        bad;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add(input logic [7:0] code, input logic bad, input logic [31:0] exp);
    vec_t v;
    v.code = code;
    v.bad  = bad;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic bad);
    logic p;
    p = (~^code) ^ bad;
    return {1'b1, p, code, 1'b0};
  endfunction

  // drive the first n bits of a frame, leaving ps2_clk high
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = f[i];
      tick(HALF);
      bus.ps2_clk = 1'b0;
      tick(HALF);
      bus.ps2_clk = 1'b1;
    end
  endtask

  // full frame; output checked 5 cycles after the stop-bit falling edge
  task automatic send_frame(input logic [7:0] code, input logic bad,
                            input logic [31:0] exp, input string name);
    logic [10:0] f;
    logic [31:0] e;
    f = mk_frame(code, bad);
    exp_q.push_back(exp);
    send_bits(f, 10);
    bus.ps2_data = f[10];
    tick(HALF);
    bus.ps2_clk = 1'b0;
    tick(5);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, bus.ps2_ascii, e);
    end
    tick(HALF - 5);
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    tick(GAP);
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;

    // expected ASCII after each frame
    add(8'h1C, 0, 32'h61); add(8'hF0, 0, 32'h61); add(8'h1C, 0, 32'h00);
    add(8'h12, 0, 32'h00); add(8'h1C, 0, 32'h41); add(8'hF0, 0, 32'h41);
    add(8'h1C, 0, 32'h00); add(8'hF0, 0, 32'h00); add(8'h12, 0, 32'h00);
    add(8'h1C, 0, 32'h61); add(8'h1C, 0, 32'h61); add(8'h32, 0, 32'h62);
    add(8'hF0, 0, 32'h62); add(8'h1C, 0, 32'h62); add(8'hF0, 0, 32'h62);
    add(8'h32, 0, 32'h00); add(8'h1C, 1, 32'h00); add(8'h16, 0, 32'h31);
    add(8'h12, 0, 32'h31); add(8'hF0, 0, 32'h31); add(8'h16, 0, 32'h00);
    add(8'hF0, 0, 32'h00); add(8'h12, 0, 32'h00); add(8'hE0, 0, 32'h00);
    add(8'h75, 0, 32'h00); add(8'hE0, 0, 32'h00); add(8'hF0, 0, 32'h00);
    add(8'h75, 0, 32'h00); add(8'h29, 0, 32'h20); add(8'h5A, 0, 32'h0D);
    add(8'h66, 0, 32'h08); add(8'h0D, 0, 32'h09); add(8'h76, 0, 32'h1B);
    add(8'h45, 0, 32'h30); add(8'h1A, 0, 32'h7A); add(8'h59, 0, 32'h7A);
    add(8'h15, 0, 32'h51); add(8'hF0, 0, 32'h51); add(8'h59, 0, 32'h51);
    add(8'h4D, 0, 32'h70); add(8'h3E, 0, 32'h38); add(8'h0E, 0, 32'h38);
    add(8'hF0, 0, 32'h38); add(8'h3E, 0, 32'h00);

    // reset state
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(2);
    check("reset_ascii", bus.ps2_ascii, 32'h0);
    check("reset_state", 32'(bus.state_dbg), 32'(ST_IDLE));

    // table
    for (int i = 0; i < vecs.size(); i++)
      send_frame(vecs[i].code, vecs[i].bad, vecs[i].exp, $sformatf("vec%0d_%02h", i, vecs[i].code));

    // partial frame abandoned, then a full frame must decode
    send_bits(mk_frame(8'h1C, 1'b0), 6);
    bus.ps2_data = 1'b1;
    tick(TO + 1);
    send_frame(8'h29, 1'b0, 32'h20, "timeout_space");

    // reset in the middle of a frame
    send_bits(mk_frame(8'h1C, 1'b0), 5);
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    check("rst_mid_ascii", bus.ps2_ascii, 32'h0);
    check("rst_mid_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    send_frame(8'h1C, 1'b0, 32'h61, "after_rst");

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key.md
PS2_KEY -- requirements
Module: ps2_key

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, SHALL set the idle sys_clk cycles after which a partial PS/2 frame is discarded.
REQ-002 sys_clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset, sampled on the sys_clk rising edge.
REQ-004 ps2_clk  input  1  SHALL be the asynchronous PS/2 device clock, treated as data and never used as a clock.
REQ-005 ps2_data  input  1  SHALL be the asynchronous PS/2 data line.
REQ-006 ps2_ascii  output  32  SHALL carry the ASCII code of the currently held key, zero-extended; 0 when no mapped key is held.

Function
REQ-007 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected from the synchronized clock's previous and current values.
REQ-008 On each detected falling edge the synchronized data bit SHALL be shifted in; frame = start 0, 8 data bits LSB first, odd parity, stop 1 (11 bits).
REQ-009 A frame SHALL be accepted only if start=0, stop=1 and the 9 data+parity bits contain an odd number of ones; otherwise it is discarded silently.
REQ-010 The bit counter SHALL return to 0 after the 11th bit, whether the frame is accepted or not.
REQ-011 If TIMEOUT_CYCLES consecutive cycles pass with no falling edge while the bit counter is non-zero, the bit counter SHALL clear and the partial frame is dropped.
REQ-012 The accepted-byte strobe SHALL assert for exactly one cycle, in the cycle the 11th falling edge is detected.
REQ-013 Decoder states: IDLE, BREAK (after 0xF0), EXT (after 0xE0), EXT_BREAK (0xE0 then 0xF0).
REQ-014 In IDLE: 0xF0 -> BREAK; 0xE0 -> EXT; 0x12 or 0x59 -> corresponding shift flag set; other codes -> make event, stay IDLE.
REQ-015 In BREAK: 0x12/0x59 -> clear that shift flag; other code equal to the held scan code -> ps2_ascii becomes 0; any code -> IDLE.
REQ-016 In EXT: 0xF0 -> EXT_BREAK; other code -> IDLE with no output change. In EXT_BREAK: any code -> IDLE, no output change (extended keys are unmapped).
REQ-017 Make event with a mapped code SHALL latch the scan code and drive ps2_ascii to its ASCII value one cycle after the strobe; unmapped make codes SHALL leave ps2_ascii and the held code unchanged.
REQ-018 Repeated make (typematic) of the held key SHALL leave ps2_ascii unchanged; make of another mapped key SHALL replace it.
REQ-019 Break of a key other than the held one SHALL not change ps2_ascii.
REQ-020 Mapping (set 2): letters 0x1C A,0x32 B,0x21 C,0x23 D,0x24 E,0x2B F,0x34 G,0x33 H,0x43 I,0x3B J,0x42 K,0x4B L,0x3A M,0x31 N,0x44 O,0x4D P,0x15 Q,0x2D R,0x1B S,0x2C T,0x3C U,0x2A V,0x1D W,0x22 X,0x35 Y,0x1A Z; lowercase (0x61-0x7A) when no shift flag set, uppercase (0x41-0x5A) when either is set.
REQ-021 Digits 0x45 '0',0x16 '1',0x1E '2',0x26 '3',0x25 '4',0x2E '5',0x36 '6',0x3D '7',0x3E '8',0x46 '9' SHALL map to 0x30-0x39 regardless of shift.
REQ-022 0x29 -> 0x20 space, 0x5A -> 0x0D enter, 0x66 -> 0x08 backspace, 0x0D -> 0x09 tab, 0x76 -> 0x1B escape, regardless of shift.
REQ-023 Shift flag changes SHALL not alter an already latched ps2_ascii value.
REQ-024 ps2_ascii[31:8] SHALL always be 0.

Reset
REQ-025 On rst: ps2_ascii=0, held code=0, shift flags clear, decoder IDLE, bit counter 0, timeout counter 0, synchronizers loaded with 1 (idle bus).
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first complete frame after reset release SHALL be decoded normally.

Structure
REQ-027 Frame length, prefix codes 0xF0/0xE0, shift codes and decoder state encoding SHALL live in a shared package ps2_pkg.
REQ-028 The scan-to-ASCII table SHALL be a combinational sub-module ps2_scan2ascii (inputs code, shift; outputs ascii, valid); everything else stays in ps2_key.

Verification
REQ-029 Frame 0x1C with correct parity -> ps2_ascii=0x00000061 within 5 cycles of the stop-bit falling edge.
REQ-030 Frames 0x12, 0x1C -> 0x41; then F0 1C -> 0; then F0 12, 1C -> 0x61.
REQ-031 Frame 0x1C with even parity (bad) -> ps2_ascii stays 0; following good 0x16 -> 0x31.
REQ-032 Hold 0x1C (0x61), send 0x32 -> 0x62; F0 1C -> stays 0x62; F0 32 -> 0.
REQ-033 Send 6 bits then idle TIMEOUT_CYCLES+1 cycles, then full frame 0x29 -> 0x20.
REQ-034 E0 75, E0 F0 75 -> stays 0; rst asserted mid-frame during 0x1C -> 0, next full 0x1C -> 0x61.
